// File: rtl/keypad_scan_debounce_pkg.sv
// -----------------------------------------------------------------------------
// keypad_scan_debounce_pkg
//
// Purpose:
//   Shared types, constants and small helpers for the keypad scanner.
//   This package has no ports. It holds:
//     - the scanner state enum
//     - the idle row and column patterns
//     - the named key codes that the plate and dot-matrix logic compare
//       against `control`
//     - pure helper functions for row rotation and row/column decoding
// -----------------------------------------------------------------------------
package keypad_scan_debounce_pkg;

    // Scanner states. The encoding is not visible outside the block.
    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2
    } state_t;

    // Row 0 is driven low first after reset.
    localparam logic [3:0] ROW_INIT = 4'b1110;

    // All columns are pulled up, so no key shows as all ones.
    localparam logic [3:0] COL_IDLE = 4'b1111;

    // Key codes are row_index*4 + col_index. Code 0 is a real key.
    localparam logic [3:0] KEY_PAUSE = 4'd0;
    localparam logic [3:0] KEY_UP    = 4'd1;
    localparam logic [3:0] KEY_LEFT  = 4'd4;
    localparam logic [3:0] KEY_START = 4'd5;
    localparam logic [3:0] KEY_RIGHT = 4'd6;
    localparam logic [3:0] KEY_DOWN  = 4'd9;

    // Move the single low bit of the row drive to the next row:
    // 1110 -> 1101 -> 1011 -> 0111 -> 1110.
    function automatic logic [3:0] next_row(input logic [3:0] row);
        return {row[2:0], row[3]};
    endfunction

    // Index of the row currently driven low.
    function automatic logic [1:0] row_index(input logic [3:0] row);
        logic [1:0] idx;
        idx = 2'd0;
        case (row)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // Lowest-numbered low column wins when several keys in one row are down.
    // Only called when at least one column bit is low.
    function automatic logic [1:0] first_low_col(input logic [3:0] col);
        logic [1:0] idx;
        if (!col[0])      idx = 2'd0;
        else if (!col[1]) idx = 2'd1;
        else if (!col[2]) idx = 2'd2;
        else              idx = 2'd3;
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scan_debounce_if.sv
// -----------------------------------------------------------------------------
// keypad_scan_debounce_if
//
// Purpose:
//   Groups the keypad pins and the debounced key outputs of the scanner.
//
// Signals:
//   keyPad_col  [3:0]  column returns from the keypad; active-low, pulled up
//   keyPad_row  [3:0]  row drive; one-hot-low
//   control     [3:0]  last confirmed key code
//   key_valid          single-cycle pulse on each confirmed press
//   key_held           high from press confirmation until release confirmation
//
// Modports:
//   master  the scanner: reads the columns, drives the rows and key outputs
//   slave   the keypad and the key consumers on the other side
// -----------------------------------------------------------------------------
interface keypad_scan_debounce_if;

    logic [3:0] keyPad_col;
    logic [3:0] keyPad_row;
    logic [3:0] control;
    logic       key_valid;
    logic       key_held;

    modport master (
        input  keyPad_col,
        output keyPad_row,
        output control,
        output key_valid,
        output key_held
    );

    modport slave (
        output keyPad_col,
        input  keyPad_row,
        input  control,
        input  key_valid,
        input  key_held
    );

endinterface

// File: rtl/keypad_scan_debounce_sync2_bus.sv
// -----------------------------------------------------------------------------
// sync2_bus
//
// Purpose:
//   Two-flop synchroniser for a bus of independent asynchronous levels.
//   Both stages reset to all ones, which is the idle level of the keypad
//   columns, so no key appears to be pressed while reset is released.
//
// Ports:
//   clock          block clock
//   reset          asynchronous, active-low reset
//   d  [WIDTH-1:0] asynchronous input levels
//   q  [WIDTH-1:0] synchronised levels, two clocks behind d
// -----------------------------------------------------------------------------
module sync2_bus #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // NOTE: clocked state uses non-blocking assignments so that both stages
    // sample their pre-edge values and the chain really is two flops deep.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scan_debounce.sv
// -----------------------------------------------------------------------------
// keypad_scan_debounce
//
// Purpose:
//   Scans a 4x4 keypad one row at a time. It synchronises and debounces the
//   column returns and reports one key code per physical press. The block
//   runs on the divided 10 kHz tick clock.
//
// Parameters:
//   SCAN_DIV        clock cycles per row slot. Must be at least 3, so that a
//                   column change caused by a new row drive has crossed the
//                   synchroniser before the slot-end sample.
//   DEBOUNCE_SCANS  number of consecutive matching slot samples needed to
//                   confirm a press, and again to confirm a release.
//
// Ports:
//   clock   block clock
//   reset   asynchronous, active-low reset
//   bus     keypad_scan_debounce_if.master. It carries:
//             - keyPad_col in
//             - keyPad_row, control, key_valid and key_held out
//
// Operation:
//   - The columns are sampled once per slot, at the last cycle of the slot.
//   - While scanning, the row drive rotates at every slot end that sees no
//     key.
//   - When a key is seen, the row freezes and that one key is debounced.
//     All other keys are ignored until the press has been rejected or the
//     release has been confirmed.
// -----------------------------------------------------------------------------
module keypad_scan_debounce
    import keypad_scan_debounce_pkg::*;
#(
    parameter int SCAN_DIV       = 4,
    parameter int DEBOUNCE_SCANS = 20
) (
    input  logic                   clock,
    input  logic                   reset,
    keypad_scan_debounce_if.master bus
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

    localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DB_TARGET = CW'(DEBOUNCE_SCANS);

    // Registered state and the next-state values computed for it.
    state_t        state_q,   state_d;
    logic [3:0]    row_q,     row_d;
    logic [SW-1:0] slot_q,    slot_d;
    logic [CW-1:0] match_q,   match_d;
    logic [CW-1:0] rel_q,     rel_d;
    logic [3:0]    code_q,    code_d;     // key under debounce: {row, col}
    logic [3:0]    control_q, control_d;
    logic          valid_q,   valid_d;
    logic          held_q,    held_d;

    logic [3:0]    col_s;
    logic          slot_end;
    logic          key_up;                // tracked column reads high

    // Counters stop at the target so that they can never wrap.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == DB_TARGET) ? v : v + 1'b1;
    endfunction

    sync2_bus #(
        .WIDTH (4)
    ) u_col_sync (
        .clock (clock),
        .reset (reset),
        .d     (bus.keyPad_col),
        .q     (col_s)
    );

    assign slot_end = (slot_q == SLOT_LAST);
    assign key_up   = col_s[code_q[1:0]];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= SCAN;
            row_q     <= ROW_INIT;
            slot_q    <= '0;
            match_q   <= '0;
            rel_q     <= '0;
            code_q    <= '0;
            control_q <= '0;
            valid_q   <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            slot_q    <= slot_d;
            match_q   <= match_d;
            rel_q     <= rel_d;
            code_q    <= code_d;
            control_q <= control_d;
            valid_q   <= valid_d;
            held_q    <= held_d;
        end
    end

    always_comb begin
        // NOTE: every value is given a default before any branch. Paths that
        // do not assign a value then keep it (or clear it) instead of
        // inferring a latch.
        state_d   = state_q;
        row_d     = row_q;
        slot_d    = slot_end ? '0 : slot_q + 1'b1;
        match_d   = match_q;
        rel_d     = rel_q;
        code_d    = code_q;
        control_d = control_q;
        valid_d   = 1'b0;                 // key_valid is only ever one cycle
        held_d    = held_q;

        if (slot_end) begin
            case (state_q)
                SCAN: begin
                    if (col_s == COL_IDLE) begin
                        row_d = next_row(row_q);
                    end else begin
                        // Row stays frozen on the key that was found.
                        code_d  = {row_index(row_q), first_low_col(col_s)};
                        match_d = CW'(1);
                        state_d = DEBOUNCE;
                    end
                end

                DEBOUNCE: begin
                    if (!key_up) begin
                        match_d = sat_inc(match_q);
                        if (match_d == DB_TARGET) begin
                            control_d = code_q;
                            valid_d   = 1'b1;
                            held_d    = 1'b1;
                            rel_d     = '0;
                            state_d   = PRESSED;
                        end
                    end else begin
                        // Bounce: drop the candidate and move on to the next
                        // row. control keeps its old value.
                        match_d = '0;
                        row_d   = next_row(row_q);
                        state_d = SCAN;
                    end
                end

                PRESSED: begin
                    // A single low sample restarts the release count. This
                    // is what rejects release chatter.
                    rel_d = key_up ? sat_inc(rel_q) : '0;
                    if (rel_d == DB_TARGET) begin
                        held_d  = 1'b0;
                        rel_d   = '0;
                        match_d = '0;
                        row_d   = next_row(row_q);
                        state_d = SCAN;
                    end
                end

                default: begin
                    state_d = SCAN;
                    row_d   = ROW_INIT;
                end
            endcase
        end
    end

    assign bus.keyPad_row = row_q;
    assign bus.control    = control_q;
    assign bus.key_valid  = valid_q;
    assign bus.key_held   = held_q;

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// -----------------------------------------------------------------------------
// tb_keypad_scan_debounce
//
// Bench for keypad_scan_debounce with SCAN_DIV=4 and DEBOUNCE_SCANS=3.
// A keypad model pulls column c low while key (r,c) is down and row r is
// driven low. The bench has three parts:
//   - hand-written multi-cycle sequences, timed from reset release
//   - a table of press/release vectors
//   - a randomized run, compared cycle by cycle against a slot-level
//     behavioural model
// -----------------------------------------------------------------------------
module tb_keypad_scan_debounce;

    localparam int SD = 4;
    localparam int DS = 3;

    localparam int M_SCAN = 0;
    localparam int M_DEB  = 1;
    localparam int M_PRS  = 2;

    logic        clock;
    logic        reset;
    logic [15:0] keys;                    // bit r*4+c: key (r,c) is down

    int n_pass;
    int n_total;

    keypad_scan_debounce_if kif ();

    keypad_scan_debounce #(
        .SCAN_DIV       (SD),
        .DEBOUNCE_SCANS (DS)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (kif)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Physical keypad: a key connects its row line to its column line.
    always_comb begin
        logic [3:0] col;
        col = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !kif.keyPad_row[r]) col[c] = 1'b0;
        kif.keyPad_col = col;
    end

    // ---------------------------------------------------------------------
    // Reference model. It works at the level of the row number, the slot
    // phase, a two-deep delay line for the column synchroniser, and the
    // press/release run lengths.
    // ---------------------------------------------------------------------
    typedef struct {
        int         row;
        int         phase;
        logic [3:0] s1;
        logic [3:0] s2;
        int         mode;
        int         cnt;
        int         rcnt;
        int         code;
        logic [3:0] control;
        logic       valid;
        logic       held;
    } model_t;

    model_t m;

    function automatic model_t model_next(model_t cur, logic [15:0] k);
        model_t     n;
        logic [3:0] smp;
        logic [3:0] col_now;
        int         cidx;
        n       = cur;
        col_now = 4'hF;
        for (int c = 0; c < 4; c++) if (k[cur.row*4+c]) col_now[c] = 1'b0;
        smp     = cur.s2;
        n.s2    = cur.s1;
        n.s1    = col_now;
        n.valid = 1'b0;
        if (cur.phase != SD - 1) begin
            n.phase = cur.phase + 1;
            return n;
        end
        n.phase = 0;
        cidx    = cur.code % 4;
        case (cur.mode)
            M_SCAN: begin
                if (smp == 4'hF) begin
                    n.row = (cur.row + 1) % 4;
                end else begin
                    for (int c = 3; c >= 0; c--) if (!smp[c]) cidx = c;
                    n.code = cur.row * 4 + cidx;
                    n.cnt  = 1;
                    n.mode = M_DEB;
                end
            end
            M_DEB: begin
                if (!smp[cidx]) begin
                    n.cnt = cur.cnt + 1;
                    if (n.cnt == DS) begin
                        n.control = 4'(cur.code);
                        n.valid   = 1'b1;
                        n.held    = 1'b1;
                        n.rcnt    = 0;
                        n.mode    = M_PRS;
                    end
                end else begin
                    n.mode = M_SCAN;
                    n.row  = (cur.row + 1) % 4;
                end
            end
            default: begin
                n.rcnt = smp[cidx] ? cur.rcnt + 1 : 0;
                if (n.rcnt == DS) begin
                    n.held = 1'b0;
                    n.mode = M_SCAN;
                    n.row  = (cur.row + 1) % 4;
                end
            end
        endcase
        return n;
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset)
            m <= '{row: 0, phase: 0, s1: 4'hF, s2: 4'hF, mode: M_SCAN, cnt: 0,
                   rcnt: 0, code: 0, control: 4'h0, valid: 1'b0, held: 1'b0};
        else
            m <= model_next(m, keys);
    end

    function automatic logic [3:0] row_vec(int r);
        logic [3:0] v;
        v    = 4'hF;
        v[r] = 1'b0;
        return v;
    endfunction

    // ---------------------------------------------------------------------
    // Helpers
    // ---------------------------------------------------------------------
    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Advance n falling edges. Count key_valid pulses and cycles with
    // key_held low along the way.
    task automatic run(input int n, output int pulses, output int held_lows);
        pulses    = 0;
        held_lows = 0;
        repeat (n) begin
            @(negedge clock);
            if (kif.key_valid) pulses++;
            if (!kif.key_held) held_lows++;
        end
    endtask

    // Assert reset with the given keys down, then release it on a falling
    // edge. The next rising edge is edge 1.
    task automatic do_reset(input logic [15:0] k);
        reset = 1'b0;
        keys  = k;
        repeat (3) @(negedge clock);
        reset = 1'b1;
    endtask

    typedef struct {
        logic [15:0] keys;
        int          hold;
        int          pulses;
        logic [3:0]  ctrl;
        logic        held;
    } vec_t;

    vec_t       vecs[7];
    logic [3:0] scan_seq[5];

    initial begin
        int p, h, tp, th;
        logic [15:0] ks;

        n_pass  = 0;
        n_total = 0;
        reset   = 1'b0;
        keys    = '0;

        // {keys, hold cycles, pulses, control afterwards, held at end of hold}
        vecs[0] = '{16'h0200,  60, 1, 4'd9,  1'b1};  // r2 c1
        vecs[1] = '{16'h0080,   5, 0, 4'd9,  1'b0};  // r1 c3, too short
        vecs[2] = '{16'h0005,  60, 1, 4'd0,  1'b1};  // r0 c0 + c2
        vecs[3] = '{16'h8000,  60, 1, 4'd15, 1'b1};  // r3 c3
        vecs[4] = '{16'h0040,  60, 1, 4'd6,  1'b1};  // r1 c2
        vecs[5] = '{16'hB000,  60, 1, 4'd12, 1'b1};  // r3 c0,c1,c3
        vecs[6] = '{16'h0008,   4, 0, 4'd12, 1'b0};  // r0 c3, too short

        scan_seq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

        // --- A: reset values and idle scanning --------------------------
        repeat (3) @(negedge clock);
        check("rst_row",     32'(kif.keyPad_row), 32'(4'b1110));
        check("rst_control", 32'(kif.control),    32'd0);
        check("rst_valid",   32'(kif.key_valid),  32'd0);
        check("rst_held",    32'(kif.key_held),   32'd0);
        reset = 1'b1;
        run(2, p, h);
        tp = p;
        check("scan_row_0", 32'(kif.keyPad_row), 32'(scan_seq[0]));
        for (int k = 1; k < 5; k++) begin
            run(SD, p, h);
            tp += p;
            check($sformatf("scan_row_%0d", k), 32'(kif.keyPad_row),
                  32'(scan_seq[k]));
        end
        check("scan_no_pulse", 32'(tp),           32'd0);
        check("scan_control",  32'(kif.control),  32'd0);
        check("scan_held",     32'(kif.key_held), 32'd0);

        // --- B: steady press r2 c1, found at edge 12, pulse at edge 20 --
        do_reset(16'h0200);
        run(19, p, h);
        check("b_no_early_pulse", 32'(p),               32'd0);
        check("b_held_before",    32'(kif.key_held),    32'd0);
        run(1, p, h);
        check("b_pulse",          32'(kif.key_valid),   32'd1);
        check("b_control",        32'(kif.control),     32'd9);
        check("b_held",           32'(kif.key_held),    32'd1);
        check("b_row_frozen",     32'(kif.keyPad_row),  32'(4'b1011));
        keys = '0;
        run(1, p, h);
        check("b_pulse_one_cycle", 32'(kif.key_valid),  32'd0);
        run(10, p, h);
        check("b_held_edge31",    32'(kif.key_held),    32'd1);
        check("b_row_edge31",     32'(kif.keyPad_row),  32'(4'b1011));
        check("b_no_repulse",     32'(p),               32'd0);
        run(1, p, h);
        check("b_release_edge32", 32'(kif.key_held),    32'd0);
        check("b_scan_resumes",   32'(kif.keyPad_row),  32'(4'b0111));

        // --- C: r1 c3 low for one slot only, then high ------------------
        do_reset(16'h0080);
        run(8, p, h);
        tp = p;
        check("c_row_frozen", 32'(kif.keyPad_row), 32'(4'b1101));
        keys = '0;
        run(3, p, h);
        tp += p;
        check("c_row_edge11", 32'(kif.keyPad_row), 32'(4'b1101));
        run(1, p, h);
        tp += p;
        check("c_next_row",   32'(kif.keyPad_row), 32'(4'b1011));
        run(4, p, h);
        tp += p;
        check("c_scanning",   32'(kif.keyPad_row), 32'(4'b0111));
        run(20, p, h);
        tp += p;
        check("c_no_pulse",   32'(tp),             32'd0);
        check("c_control",    32'(kif.control),    32'd0);
        check("c_held",       32'(kif.key_held),   32'd0);

        // --- D: r0 c0 + r0 c2 together, then r3 c3 added while held -----
        do_reset(16'h0005);
        run(11, p, h);
        check("d_no_early_pulse", 32'(p),              32'd0);
        run(1, p, h);
        check("d_pulse",          32'(kif.key_valid),  32'd1);
        check("d_control",        32'(kif.control),    32'd0);
        check("d_held",           32'(kif.key_held),   32'd1);
        keys = 16'h8005;
        run(40, p, h);
        tp = p;
        check("d_held_long",      32'(kif.key_held),   32'd1);
        keys = '0;
        run(11, p, h);
        tp += p;
        check("d_held_edge63",    32'(kif.key_held),   32'd1);
        run(1, p, h);
        tp += p;
        check("d_release_edge64", 32'(kif.key_held),   32'd0);
        check("d_next_row",       32'(kif.keyPad_row), 32'(4'b1101));
        check("d_no_rollover",    32'(tp),             32'd0);

        // --- E: release chatter, one slot per level ---------------------
        do_reset(16'h0001);
        run(12, p, h);
        check("e_pulse", 32'(kif.key_valid), 32'd1);
        tp = 0;
        th = 0;
        for (int j = 0; j < 5; j++) begin
            keys = (j % 2 == 1) ? 16'h0001 : 16'h0000;
            run(SD, p, h);
            tp += p;
            th += h;
        end
        keys = '0;
        run(7, p, h);
        tp += p;
        th += h;
        check("e_held_through_chatter", 32'(th), 32'd0);
        check("e_no_pulse_chatter",     32'(tp), 32'd0);
        run(1, p, h);
        check("e_release_edge40", 32'(kif.key_held), 32'd0);

        // --- F: reset asserted two cycles after the pulse ---------------
        do_reset(16'h0200);
        run(20, p, h);
        check("f_pulse", 32'(kif.key_valid), 32'd1);
        run(2, p, h);
        reset = 1'b0;
        #1;
        check("f_rst_row",     32'(kif.keyPad_row), 32'(4'b1110));
        check("f_rst_control", 32'(kif.control),    32'd0);
        check("f_rst_valid",   32'(kif.key_valid),  32'd0);
        check("f_rst_held",    32'(kif.key_held),   32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        run(19, p, h);
        check("f_no_stale_pulse", 32'(p),             32'd0);
        run(1, p, h);
        check("f_new_pulse",      32'(kif.key_valid), 32'd1);
        check("f_new_control",    32'(kif.control),   32'd9);
        run(20, p, h);
        check("f_single_pulse",   32'(p),             32'd0);
        check("f_still_held",     32'(kif.key_held),  32'd1);

        // --- Table-driven press/release vectors -------------------------
        do_reset('0);
        for (int i = 0; i < 7; i++) begin
            keys = vecs[i].keys;
            run(vecs[i].hold, p, h);
            tp = p;
            check($sformatf("v%0d_held_during", i), 32'(kif.key_held),
                  32'(vecs[i].held));
            keys = '0;
            run(40, p, h);
            tp += p;
            check($sformatf("v%0d_pulses", i),  32'(tp),
                  32'(vecs[i].pulses));
            check($sformatf("v%0d_control", i), 32'(kif.control),
                  32'(vecs[i].ctrl));
            check($sformatf("v%0d_released", i), 32'(kif.key_held), 32'd0);
        end

        // --- Randomized run against the reference model -----------------
        do_reset('0);
        for (int ep = 0; ep < 60; ep++) begin
            int hold;
            int rel;
            ks = 16'h0001 << $urandom_range(0, 15);
            if ($urandom_range(0, 3) == 0) ks |= 16'h0001 << $urandom_range(0, 15);
            hold = int'($urandom_range(2, 60));
            rel  = int'($urandom_range(2, 40));
            for (int i = 0; i < hold + rel; i++) begin
                if (i < hold) keys = ($urandom_range(0, 9) == 0) ? 16'h0000 : ks;
                else          keys = 16'h0000;
                @(negedge clock);
                check("rand_outputs",
                      32'({kif.keyPad_row, kif.control, kif.key_valid, kif.key_held}),
                      32'({row_vec(m.row), m.control, m.valid, m.held}));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
